axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave.sv | 207 ++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_ram_slave (with package axi_ram_pkg)
// Purpose  : AXI3-style slave backed by a MEM_WORDS x 32 register array.
//            Independent read and write FSMs, one outstanding transaction
//            each, one beat per cycle when the master streams.
// Ports    : clk      - single clock, rising edge
//            rst      - synchronous active-high reset
//            axi_req  - master channels: AR, R-ready, AW, W, B-ready
//            axi_resp - slave channels : AR-ready, R, AW-ready, W-ready, B
// Revision : 1.0 - initial release
// ============================================================================

package axi_ram_pkg;
  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
  } axi_resp_t;
endpackage

module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic      clk,
  input  logic      rst,
  input  axi_req_t  axi_req,
  output axi_resp_t axi_resp
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  logic [31:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- read path
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  rd_state_t rd_state, rd_state_nxt;

  logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
  logic [3:0]       rd_len, rd_cnt;
  logic [1:0]       rd_burst;
  logic             rd_err;
  logic [31:0]      rd_word;
  logic             ar_hs, r_hs, rd_last;
  logic [IDX_W-1:0] ar_idx;

  assign ar_idx     = axi_req.araddr[IDX_W+1:2];
  assign ar_hs      = (rd_state == R_IDLE) && axi_req.arvalid;
  assign r_hs       = (rd_state == R_DATA) && axi_req.rready;
  assign rd_last    = (rd_state == R_DATA) && (rd_cnt == rd_len);
  // FIXED holds the address; every other burst code advances like INCR.
  assign rd_idx_nxt = (rd_burst == BURST_FIXED) ? rd_idx : rd_idx + IDX_W'(1);

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)            rd_state_nxt = R_DATA;
      R_DATA:  if (r_hs && rd_last)  rd_state_nxt = R_IDLE;
      default:                       rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_burst <= '0;
      rd_err   <= 1'b0;
      rd_word  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ar_hs) begin
        rd_idx   <= ar_idx;
        rd_len   <= axi_req.arlen;
        rd_burst <= axi_req.arburst;
        rd_err   <= (axi_req.arsize != SIZE_WORD);
        rd_cnt   <= '0;
        rd_word  <= mem[ar_idx];
      end else if (r_hs && !rd_last) begin
        rd_cnt  <= rd_cnt + 4'd1;
        rd_idx  <= rd_idx_nxt;
        // Non-blocking read of the array: a same-edge write is seen next beat.
        rd_word <= mem[rd_idx_nxt];
      end
    end
  end

  // --------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
  wr_state_t wr_state, wr_state_nxt;

  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_len, wr_cnt;
  logic [1:0]       wr_burst;
  logic             wr_err, b_err;
  logic             aw_hs, w_hs, b_hs;

  assign aw_hs = (wr_state == W_IDLE) && axi_req.awvalid;
  assign w_hs  = (wr_state == W_DATA) && axi_req.wvalid;
  assign b_hs  = (wr_state == W_RESP) && axi_req.bready;

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs)                 wr_state_nxt = W_DATA;
      W_DATA:  if (w_hs && axi_req.wlast) wr_state_nxt = W_RESP;
      W_RESP:  if (b_hs)                  wr_state_nxt = W_IDLE;
      default:                            wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_burst <= '0;
      wr_err   <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if (aw_hs) begin
        wr_idx   <= axi_req.awaddr[IDX_W+1:2];
        wr_len   <= axi_req.awlen;
        wr_burst <= axi_req.awburst;
        wr_err   <= (axi_req.awsize != SIZE_WORD);
        wr_cnt   <= '0;
      end else if (w_hs) begin
        wr_cnt <= wr_cnt + 4'd1;
        wr_idx <= (wr_burst == BURST_FIXED) ? wr_idx : wr_idx + IDX_W'(1);
        if (axi_req.wlast) begin
          // Beat count matches only if this is beat wr_len and no overrun happened.
          b_err <= wr_err || (wr_cnt != wr_len);
        end else if (wr_cnt == wr_len) begin
          // Overrun: the counter may wrap later, so the error is made sticky here.
          wr_err <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately never reset; partial bursts survive a reset.
  always_ff @(posedge clk) begin
    if (w_hs && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_req.wstrb[i]) mem[wr_idx][8*i +: 8] <= axi_req.wdata[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    axi_resp         = '0;
    axi_resp.arready = (rd_state == R_IDLE);
    axi_resp.rvalid  = (rd_state == R_DATA);
    axi_resp.rdata   = rd_word;
    axi_resp.rresp   = ((rd_state == R_DATA) && rd_err) ? RESP_SLVERR : RESP_OKAY;
    axi_resp.rlast   = rd_last;
    axi_resp.awready = (wr_state == W_IDLE);
    axi_resp.wready  = (wr_state == W_DATA);
    axi_resp.bvalid  = (wr_state == W_RESP);
    axi_resp.bresp   = ((wr_state == W_RESP) && b_err) ? RESP_SLVERR : RESP_OKAY;
  end

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_req.araddr[31:IDX_W+2], axi_req.araddr[1:0],
                              axi_req.awaddr[31:IDX_W+2], axi_req.awaddr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axi_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_ram_slave
// Purpose  : Self-checking bench for axi_ram_slave. A word-array model of the
//            memory is updated from every accepted write beat; reads and
//            responses are compared with values derived from the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ram_slave;
  import axi_ram_pkg::*;

  localparam int MW = 256;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  req;
  axi_resp_t resp;

  axi_ram_slave #(.MEM_WORDS(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .axi_req  (req),
    .axi_resp (resp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [MW];

  // Results gathered by the bus drivers.
  logic [31:0] rd_data [32];
  logic [1:0]  rd_resp [32];
  logic        rd_last [32];
  int          rd_n, rd_stall_changes, rd_cycles;
  logic [31:0] wr_data [32];
  logic [3:0]  wr_strb [32];
  logic [1:0]  b_resp;
  int          b_changes, w_wait;

  // Word index of beat 'beat' of a burst: FIXED stays put, everything else steps.
  function automatic int widx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int base;
    base = int'(addr >> 2);
    if (burst == 2'b00) return base % MW;
    return (base + beat) % MW;
  endfunction

  // ---------------------------------------------------------- bus drivers
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int nbeats, input bit gaps);
    int cyc;
    bit seen;
    bit done;
    b_resp = 2'bxx; b_changes = 0; w_wait = 0;
    req.awaddr = addr; req.awlen = len; req.awsize = size; req.awburst = burst;
    req.awvalid = 1'b1;
    cyc = 0;
    while (!resp.awready) begin
      @(negedge clk); cyc++;
      if (cyc > 100) begin
        tests++; fails++;
        $display("FAIL aw_timeout: awready=0 for %0d cycles, required 1", cyc);
        req.awvalid = 1'b0; return;
      end
    end
    @(negedge clk);
    req.awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        req.wvalid = 1'b0; @(negedge clk);
      end
      req.wvalid = 1'b1; req.wdata = wr_data[b]; req.wstrb = wr_strb[b];
      req.wlast  = (b == nbeats - 1);
      cyc = 0;
      while (!resp.wready) begin
        @(negedge clk); cyc++; w_wait++;
        if (cyc > 100) begin
          tests++; fails++;
          $display("FAIL w_timeout: wready=0 on beat %0d, required 1", b);
          req.wvalid = 1'b0; req.wlast = 1'b0; return;
        end
      end
      for (int i = 0; i < 4; i++)
        if (wr_strb[b][i]) model_mem[widx(addr, burst, b)][8*i +: 8] = wr_data[b][8*i +: 8];
      @(negedge clk);
    end
    req.wvalid = 1'b0; req.wlast = 1'b0;
    cyc = 0; seen = 1'b0; done = 1'b0;
    while (!done) begin
      req.bready = 1'($urandom % 2);
      if (resp.bvalid) begin
        if (seen && (resp.bresp !== b_resp)) b_changes++;
        b_resp = resp.bresp; seen = 1'b1;
        if (req.bready) done = 1'b1;
      end
      @(negedge clk); cyc++;
      if (!done && cyc > 100) begin
        tests++; fails++;
        $display("FAIL b_timeout: bvalid handshake missing after %0d cycles", cyc);
        done = 1'b1;
      end
    end
    req.bready = 1'b0;
  endtask

  // mode 0: rready held high, 1: toggles 1,0,1,0..., 2: random
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
    int cyc;
    int ph;
    bit stalled;
    bit done;
    logic [31:0] pd;
    logic [1:0]  pr;
    logic        pl;
    rd_n = 0; rd_stall_changes = 0; rd_cycles = 0;
    pd = '0; pr = '0; pl = 1'b0;
    req.araddr = addr; req.arlen = len; req.arsize = size; req.arburst = burst;
    req.arvalid = 1'b1;
    cyc = 0;
    while (!resp.arready) begin
      @(negedge clk); cyc++;
      if (cyc > 100) begin
        tests++; fails++;
        $display("FAIL ar_timeout: arready=0 for %0d cycles, required 1", cyc);
        req.arvalid = 1'b0; return;
      end
    end
    @(negedge clk);
    req.arvalid = 1'b0;
    ph = 0; stalled = 1'b0; done = 1'b0; cyc = 0;
    while (!done) begin
      if (mode == 0)      req.rready = 1'b1;
      else if (mode == 1) req.rready = (ph % 2 == 0);
      else                req.rready = 1'($urandom % 2);
      ph++; rd_cycles++;
      if (resp.rvalid) begin
        if (stalled && (resp.rdata !== pd || resp.rresp !== pr || resp.rlast !== pl))
          rd_stall_changes++;
        if (req.rready) begin
          rd_data[rd_n] = resp.rdata; rd_resp[rd_n] = resp.rresp; rd_last[rd_n] = resp.rlast;
          rd_n++; stalled = 1'b0;
          if (resp.rlast || rd_n >= 32) done = 1'b1;
        end else begin
          pd = resp.rdata; pr = resp.rresp; pl = resp.rlast; stalled = 1'b1;
        end
      end
      @(negedge clk); cyc++;
      if (!done && cyc > 200) begin
        tests++; fails++;
        $display("FAIL r_timeout: burst incomplete after %0d cycles, beats=%0d", cyc, rd_n);
        done = 1'b1;
      end
    end
    req.rready = 1'b0;
  endtask

  // -------------------------------------------------------------- scenarios
  task automatic test_reset;
    rst = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({resp.arready, resp.awready} !== 2'b11) begin
        fails++; $display("FAIL reset_ready[%0d]: ar/awready=%b required 11", k, {resp.arready, resp.awready});
      end
      tests++;
      if ({resp.rvalid, resp.rlast, resp.wready, resp.bvalid} !== 4'b0000) begin
        fails++; $display("FAIL reset_valid[%0d]: rvalid,rlast,wready,bvalid=%b required 0000", k,
                          {resp.rvalid, resp.rlast, resp.wready, resp.bvalid});
      end
      tests++;
      if ({resp.rresp, resp.bresp} !== 4'b0000) begin
        fails++; $display("FAIL reset_resp[%0d]: rresp,bresp=%b required 0000", k, {resp.rresp, resp.bresp});
      end
      tests++;
      if (resp.rdata !== 32'h0) begin
        fails++; $display("FAIL reset_rdata[%0d]: rdata=%h required 00000000", k, resp.rdata);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_fill;
    for (int blk = 0; blk < MW / 16; blk++) begin
      for (int b = 0; b < 16; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
      write_burst(32'(blk * 64), 4'd15, 3'b010, 2'b01, 16, 1'b0);
      tests++;
      if (b_resp !== 2'b00) begin
        fails++; $display("FAIL fill_bresp[%0d]: bresp=%b required 00", blk, b_resp);
      end
    end
  endtask

  task automatic test_single;
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
    write_burst(32'h100, 4'd0, 3'b010, 2'b01, 1, 1'b0);
    tests++;
    if (b_resp !== 2'b00) begin fails++; $display("FAIL single_bresp: bresp=%b required 00", b_resp); end
    read_burst(32'h100, 4'd0, 3'b010, 2'b01, 0);
    tests++;
    if (rd_n !== 1 || rd_data[0] !== 32'h11223344 || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
      fails++; $display("FAIL single_read: beats=%0d data=%h last=%b resp=%b required 1 11223344 1 00",
                        rd_n, rd_data[0], rd_last[0], rd_resp[0]);
    end
  endtask

  task automatic test_incr_stall;
    for (int b = 0; b < 4; b++) begin wr_data[b] = 32'(b + 1); wr_strb[b] = 4'hF; end
    write_burst(32'h200, 4'd3, 3'b010, 2'b01, 4, 1'b0);
    tests++;
    if (b_resp !== 2'b00) begin fails++; $display("FAIL incr_bresp: bresp=%b required 00", b_resp); end
    read_burst(32'h200, 4'd3, 3'b010, 2'b01, 1);
    tests++;
    if (rd_n !== 4) begin fails++; $display("FAIL incr_beats: beats=%0d required 4", rd_n); end
    for (int b = 0; b < 4 && b < rd_n; b++) begin
      tests++;
      if (rd_data[b] !== 32'(b + 1) || rd_last[b] !== (b == 3)) begin
        fails++; $display("FAIL incr_beat[%0d]: data=%h last=%b required %h %b", b, rd_data[b],
                          rd_last[b], 32'(b + 1), (b == 3));
      end
    end
    tests++;
    if (rd_stall_changes !== 0) begin
      fails++; $display("FAIL incr_stall_stable: changes=%0d required 0", rd_stall_changes);
    end
  endtask

  task automatic test_strobe;
    wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
    write_burst(32'h40, 4'd0, 3'b010, 2'b01, 1, 1'b0);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    write_burst(32'h40, 4'd0, 3'b010, 2'b01, 1, 1'b0);
    read_burst(32'h40, 4'd0, 3'b010, 2'b01, 0);
    tests++;
    if (rd_data[0] !== 32'h00BB00DD) begin
      fails++; $display("FAIL strobe_read: data=%h required 00bb00dd", rd_data[0]);
    end
  endtask

  task automatic test_errors;
    for (int b = 0; b < 2; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
    write_burst(32'h280, 4'd3, 3'b010, 2'b01, 2, 1'b1);
    tests++;
    if (b_resp !== 2'b10 || b_changes !== 0) begin
      fails++; $display("FAIL early_wlast_bresp: bresp=%b changes=%0d required 10 0", b_resp, b_changes);
    end
    read_burst(32'h280, 4'd2, 3'b001, 2'b01, 2);
    tests++;
    if (rd_n !== 3) begin fails++; $display("FAIL size_err_beats: beats=%0d required 3", rd_n); end
    for (int b = 0; b < 3 && b < rd_n; b++) begin
      tests++;
      if (rd_resp[b] !== 2'b10 || rd_data[b] !== model_mem[widx(32'h280, 2'b01, b)]) begin
        fails++; $display("FAIL size_err_beat[%0d]: resp=%b data=%h required 10 %h", b, rd_resp[b],
                          rd_data[b], model_mem[widx(32'h280, 2'b01, b)]);
      end
    end
  endtask

  task automatic test_fixed_alias;
    wr_data[0] = 32'hCAFE0004; wr_strb[0] = 4'hF;
    write_burst(32'h10, 4'd0, 3'b010, 2'b01, 1, 1'b0);
    read_burst(32'h10, 4'd2, 3'b010, 2'b00, 2);
    tests++;
    if (rd_n !== 3) begin fails++; $display("FAIL fixed_beats: beats=%0d required 3", rd_n); end
    for (int b = 0; b < 3 && b < rd_n; b++) begin
      tests++;
      if (rd_data[b] !== 32'hCAFE0004) begin
        fails++; $display("FAIL fixed_beat[%0d]: data=%h required cafe0004", b, rd_data[b]);
      end
    end
    read_burst(32'h10 + MW * 4, 4'd0, 3'b010, 2'b01, 0);
    tests++;
    if (rd_data[0] !== 32'hCAFE0004) begin
      fails++; $display("FAIL alias_read: data=%h required cafe0004", rd_data[0]);
    end
    // FIXED write: every beat lands on the same word, last one wins.
    for (int b = 0; b < 3; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
    write_burst(32'h10, 4'd2, 3'b010, 2'b00, 3, 1'b0);
    read_burst(32'h14, 4'd0, 3'b010, 2'b01, 0);
    tests++;
    if (rd_data[0] !== model_mem[5]) begin
      fails++; $display("FAIL fixed_write_neighbour: data=%h required %h", rd_data[0], model_mem[5]);
    end
    read_burst(32'h10, 4'd0, 3'b010, 2'b01, 0);
    tests++;
    if (rd_data[0] !== wr_data[2]) begin
      fails++; $display("FAIL fixed_write_last: data=%h required %h", rd_data[0], wr_data[2]);
    end
  endtask

  task automatic test_overrun_and_zero_strb;
    for (int b = 0; b < 4; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
    write_burst(32'h300, 4'd1, 3'b010, 2'b01, 4, 1'b0);
    tests++;
    if (b_resp !== 2'b10) begin fails++; $display("FAIL overrun_bresp: bresp=%b required 10", b_resp); end
    read_burst(32'h300, 4'd3, 3'b010, 2'b01, 0);
    for (int b = 0; b < 4; b++) begin
      tests++;
      if (rd_data[b] !== wr_data[b]) begin
        fails++; $display("FAIL overrun_data[%0d]: data=%h required %h", b, rd_data[b], wr_data[b]);
      end
    end
    wr_data[0] = $urandom; wr_strb[0] = 4'h0;
    wr_data[1] = $urandom; wr_strb[1] = 4'hF;
    write_burst(32'h340, 4'd1, 3'b010, 2'b01, 2, 1'b0);
    tests++;
    if (b_resp !== 2'b00) begin fails++; $display("FAIL zero_strb_bresp: bresp=%b required 00", b_resp); end
    read_burst(32'h340, 4'd1, 3'b010, 2'b01, 0);
    tests++;
    if (rd_data[0] !== model_mem[widx(32'h340, 2'b01, 0)] || rd_data[1] !== wr_data[1]) begin
      fails++; $display("FAIL zero_strb_data: data=%h,%h required %h,%h", rd_data[0], rd_data[1],
                        model_mem[widx(32'h340, 2'b01, 0)], wr_data[1]);
    end
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 8; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
    write_burst(32'h380, 4'd7, 3'b010, 2'b01, 8, 1'b0);
    tests++;
    if (w_wait !== 0) begin fails++; $display("FAIL w_throughput: wait cycles=%0d required 0", w_wait); end
    read_burst(32'h380, 4'd7, 3'b010, 2'b01, 0);
    tests++;
    if (rd_cycles !== 8 || rd_n !== 8) begin
      fails++; $display("FAIL r_throughput: cycles=%0d beats=%0d required 8 8", rd_cycles, rd_n);
    end
  endtask

  task automatic test_same_edge;
    logic [31:0] old_w, new_w;
    old_w = model_mem[widx(32'h500, 2'b00, 0)];
    new_w = ~old_w;
    req.awaddr = 32'h500; req.awlen = 4'd0; req.awsize = 3'b010; req.awburst = 2'b01;
    req.awvalid = 1'b1;
    @(negedge clk);
    req.awvalid = 1'b0;
    req.wvalid = 1'b1; req.wdata = new_w; req.wstrb = 4'hF; req.wlast = 1'b1;
    req.araddr = 32'h500; req.arlen = 4'd1; req.arsize = 3'b010; req.arburst = 2'b00;
    req.arvalid = 1'b1; req.rready = 1'b0;
    @(negedge clk);
    req.arvalid = 1'b0; req.wvalid = 1'b0; req.wlast = 1'b0; req.bready = 1'b1;
    model_mem[widx(32'h500, 2'b00, 0)] = new_w;
    tests++;
    if (resp.rvalid !== 1'b1 || resp.rdata !== old_w) begin
      fails++; $display("FAIL same_edge_old: rvalid=%b data=%h required 1 %h", resp.rvalid, resp.rdata, old_w);
    end
    tests++;
    if (resp.bvalid !== 1'b1 || resp.bresp !== 2'b00) begin
      fails++; $display("FAIL same_edge_b: bvalid=%b bresp=%b required 1 00", resp.bvalid, resp.bresp);
    end
    req.rready = 1'b1;
    @(negedge clk);
    tests++;
    if (resp.rdata !== new_w || resp.rlast !== 1'b1) begin
      fails++; $display("FAIL same_edge_new: data=%h last=%b required %h 1", resp.rdata, resp.rlast, new_w);
    end
    @(negedge clk);
    req.rready = 1'b0; req.bready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    for (int it = 0; it < 20; it++) begin
      addr  = $urandom & 32'hFFFF_FFFC;
      len   = 4'($urandom_range(0, 7));
      burst = 2'($urandom % 4);
      for (int b = 0; b <= int'(len); b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'($urandom); end
      write_burst(addr, len, 3'b010, burst, int'(len) + 1, 1'b1);
      tests++;
      if (b_resp !== 2'b00 || b_changes !== 0) begin
        fails++; $display("FAIL rand_bresp[%0d]: bresp=%b changes=%0d required 00 0", it, b_resp, b_changes);
      end
      read_burst(addr, len, 3'b010, burst, 2);
      tests++;
      if (rd_n !== int'(len) + 1 || rd_stall_changes !== 0) begin
        fails++; $display("FAIL rand_shape[%0d]: beats=%0d changes=%0d required %0d 0", it, rd_n,
                          rd_stall_changes, int'(len) + 1);
      end
      for (int b = 0; b < rd_n && b <= int'(len); b++) begin
        tests++;
        if (rd_data[b] !== model_mem[widx(addr, burst, b)] || rd_resp[b] !== 2'b00 ||
            rd_last[b] !== (b == int'(len))) begin
          fails++; $display("FAIL rand_beat[%0d.%0d]: data=%h resp=%b last=%b required %h 00 %b", it, b,
                            rd_data[b], rd_resp[b], rd_last[b], model_mem[widx(addr, burst, b)], (b == int'(len)));
        end
      end
    end
  endtask

  task automatic test_reset_midburst;
    logic [31:0] a0, a1;
    a0 = $urandom; a1 = $urandom;
    req.awaddr = 32'h400; req.awlen = 4'd3; req.awsize = 3'b010; req.awburst = 2'b01; req.awvalid = 1'b1;
    req.araddr = 32'h300; req.arlen = 4'd3; req.arsize = 3'b010; req.arburst = 2'b01; req.arvalid = 1'b1;
    @(negedge clk);
    req.awvalid = 1'b0; req.arvalid = 1'b0;
    req.wvalid = 1'b1; req.wdata = a0; req.wstrb = 4'hF; req.wlast = 1'b0; req.rready = 1'b1;
    @(negedge clk);
    model_mem[widx(32'h400, 2'b01, 0)] = a0;
    req.wdata = a1; req.rready = 1'b0;
    @(negedge clk);
    model_mem[widx(32'h400, 2'b01, 1)] = a1;
    req.wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({resp.rvalid, resp.rlast, resp.bvalid, resp.wready, resp.arready, resp.awready} !== 6'b000011) begin
        fails++; $display("FAIL midburst_reset[%0d]: rvalid,rlast,bvalid,wready,arready,awready=%b required 000011",
                          k, {resp.rvalid, resp.rlast, resp.bvalid, resp.wready, resp.arready, resp.awready});
      end
      rst = 1'b0;
      @(negedge clk);
    end
    read_burst(32'h400, 4'd1, 3'b010, 2'b01, 0);
    tests++;
    if (rd_n !== 2 || rd_data[0] !== a0 || rd_data[1] !== a1) begin
      fails++; $display("FAIL midburst_partial: beats=%0d data=%h,%h required 2 %h,%h", rd_n, rd_data[0],
                        rd_data[1], a0, a1);
    end
    read_burst(32'h408, 4'd0, 3'b010, 2'b01, 0);
    tests++;
    if (rd_n !== 1 || rd_last[0] !== 1'b1 || rd_data[0] !== model_mem[widx(32'h408, 2'b01, 0)]) begin
      fails++; $display("FAIL midburst_after: beats=%0d last=%b data=%h required 1 1 %h", rd_n, rd_last[0],
                        rd_data[0], model_mem[widx(32'h408, 2'b01, 0)]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0;
    test_reset;
    test_fill;
    test_single;
    test_incr_stall;
    test_strobe;
    test_errors;
    test_fixed_alias;
    test_overrun_and_zero_strb;
    test_back_to_back;
    test_same_edge;
    test_random;
    test_reset_midburst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
